// File: rtl/led_seq_pkg.sv
// Shared constants for the LED chaser receive-side decoder: pattern width,
// mode encodings and the orbit end points of each chaser mode.
package led_seq_pkg;

    localparam int LED_W     = 6;
    localparam int NUM_MODES = 3;

    typedef logic [LED_W-1:0] led_t;

    localparam logic [1:0] MODE_DOWN   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_CONV   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam led_t DOWN_TOP  = 6'd17;
    localparam led_t DOWN_BOT  = 6'd8;
    localparam led_t SHIFT_TOP = 6'd31;
    localparam led_t CONV_TOP  = 6'd63;

endpackage

// File: rtl/led_seq_next.sv
// Successor function of one chaser mode: the pattern that must follow prev,
// and whether prev belongs to that mode's orbit at all.
module led_seq_next
    import led_seq_pkg::*;
(
    input  logic [LED_W-1:0] prev,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] nxt,
    output logic             in_orbit
);

    logic [2:0] conv_hi;
    logic [2:0] conv_lo;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nxt      = '0;
        in_orbit = 1'b0;
        conv_hi  = 3'((prev[5:3] >> 1) + 3'b100);
        conv_lo  = 3'((prev[2:0] << 1) + 3'b001);
        case (mode)
            MODE_DOWN: begin
                in_orbit = (prev >= DOWN_BOT) && (prev <= DOWN_TOP);
                nxt      = (prev == DOWN_BOT) ? DOWN_TOP : prev - 6'd1;
            end
            MODE_SHIFT: begin
                // Orbit is the all-ones-from-bit-0 patterns 31..0; 63 belongs to converge-fill.
                in_orbit = ((prev & (prev + 6'd1)) == 6'd0) && (prev != CONV_TOP);
                nxt      = (prev == 6'd0) ? SHIFT_TOP : prev >> 1;
            end
            MODE_CONV: begin
                in_orbit = (prev == 6'd0) || (prev == 6'd33) ||
                           (prev == 6'd51) || (prev == CONV_TOP);
                nxt      = (prev == CONV_TOP) ? 6'd0 : {conv_hi, conv_lo};
            end
            default: begin
                in_orbit = 1'b0;
                nxt      = '0;
            end
        endcase
    end

endmodule

// File: rtl/led_seq_decoder.sv
// Chaser pattern checker: identifies the running mode, reports lock, mismatch and freeze.
// Optional saturating mismatch counter port enabled by `define LED_DEC_STATS_EN.
module led_seq_decoder
    import led_seq_pkg::*;
#(
    parameter int LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [LED_W-1:0] q_in,
    output logic [1:0]       mode_det,
    output logic             locked,
    output logic             mismatch,
    output logic             frozen
`ifdef LED_DEC_STATS_EN
    ,
    output logic [15:0]      mismatch_cnt
`endif
);

    localparam logic [1:0] ST_UNPRIMED = 2'd0;
    localparam logic [1:0] ST_HUNT     = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam logic [2:0] LOCK_MAX = 3'(LOCK_COUNT);

    logic [1:0]                  state;
    logic [LED_W-1:0]            prev;
    logic [NUM_MODES-1:0][2:0]   run;
    logic [NUM_MODES-1:0][2:0]   run_nxt;
    logic [NUM_MODES-1:0][LED_W-1:0] nxt;
    logic [NUM_MODES-1:0]        in_orbit;
    logic [NUM_MODES-1:0]        hit;
    logic [NUM_MODES-1:0]        reached;
    logic [3:0]                  hit_ext;
    logic                        cur_hit;
    logic                        changed;
    logic                        mismatch_set;
    logic                        any_reached;
    logic [1:0]                  lock_mode;

    for (genvar g = 0; g < NUM_MODES; g++) begin : g_next
        led_seq_next u_next (
            .prev     (prev),
            .mode     (2'(g)),
            .nxt      (nxt[g]),
            .in_orbit (in_orbit[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_MODES; i++) begin
            hit[i]     = in_orbit[i] && (q_in == nxt[i]);
            run_nxt[i] = !hit[i] ? 3'd0 : (run[i] == LOCK_MAX) ? run[i] : run[i] + 3'd1;
            reached[i] = (run_nxt[i] == LOCK_MAX);
        end
    end

    // Tie-break on simultaneous lock: down-count beats shift-fill beats converge-fill.
    always_comb begin
        any_reached = |reached;
        lock_mode   = MODE_DOWN;
        if (reached[0])      lock_mode = MODE_DOWN;
        else if (reached[1]) lock_mode = MODE_SHIFT;
        else if (reached[2]) lock_mode = MODE_CONV;
    end

    assign hit_ext      = {1'b0, hit};
    assign cur_hit      = hit_ext[mode_det];
    assign changed      = (q_in != prev);
    assign mismatch_set = step && (state == ST_LOCKED) && changed && !cur_hit;
    assign locked       = (state == ST_LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_UNPRIMED;
            prev     <= '0;
            run      <= '0;
            mode_det <= MODE_DOWN;
            mismatch <= 1'b0;
            frozen   <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (step) begin
                if (state == ST_UNPRIMED) begin
                    prev  <= q_in;
                    state <= ST_HUNT;
                end else if (!changed) begin
                    frozen <= 1'b1;
                end else begin
                    frozen <= 1'b0;
                    prev   <= q_in;
                    run    <= run_nxt;
                    if (state == ST_LOCKED) begin
                        if (mismatch_set) begin
                            mismatch <= 1'b1;
                            state    <= ST_HUNT;
                        end
                    end else if (any_reached) begin
                        state    <= ST_LOCKED;
                        mode_det <= lock_mode;
                    end
                end
            end
        end
    end

`ifdef LED_DEC_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_cnt <= '0;
        end else if (mismatch_set && (mismatch_cnt != 16'hFFFF)) begin
            mismatch_cnt <= mismatch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_led_seq_decoder.sv
// Scoreboard bench for led_seq_decoder: a table-driven model pushes expected
// outputs per step; a monitor pops and compares one cycle after each sampled step.
module tb_led_seq_decoder;

    localparam int LOCK = 3;

    typedef struct {
        logic        locked;
        logic [1:0]  mode;
        logic        mism;
        logic        frozen;
        logic [15:0] cnt;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       step;
    logic [5:0] q_in;
    logic [1:0] mode_det;
    logic       locked;
    logic       mismatch;
    logic       frozen;
`ifdef LED_DEC_STATS_EN
    logic [15:0] mismatch_cnt;
`endif

    led_seq_decoder #(.LOCK_COUNT(LOCK)) dut (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .q_in     (q_in),
        .mode_det (mode_det),
        .locked   (locked),
        .mismatch (mismatch),
        .frozen   (frozen)
`ifdef LED_DEC_STATS_EN
        ,
        .mismatch_cnt (mismatch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_steps = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0d, want %0d", tag, n_steps, obs, exp);
        end
    endtask

    // Orbits listed in chaser order; the successor is simply the next list entry.
    int orb_down [10] = '{17, 16, 15, 14, 13, 12, 11, 10, 9, 8};
    int orb_shift[6]  = '{31, 15, 7, 3, 1, 0};
    int orb_conv [4]  = '{0, 33, 51, 63};

    function automatic int orbit_len(input int m);
        return (m == 0) ? 10 : (m == 1) ? 6 : 4;
    endfunction

    function automatic int orbit_at(input int m, input int i);
        int k;
        k = i % orbit_len(m);
        return (m == 0) ? orb_down[k] : (m == 1) ? orb_shift[k] : orb_conv[k];
    endfunction

    function automatic bit model_hit(input int m, input int p, input int q);
        for (int i = 0; i < orbit_len(m); i++)
            if (orbit_at(m, i) == p) return (orbit_at(m, i + 1) == q);
        return 1'b0;
    endfunction

    bit          m_pv;
    int          m_prev;
    int          m_run[3];
    bit          m_locked;
    int          m_mode;
    bit          m_mism;
    bit          m_frozen;
    int          m_cnt;
    exp_t        exp_q[$];

    task automatic model_reset();
        m_pv = 0; m_prev = 0; m_locked = 0; m_mode = 0;
        m_mism = 0; m_frozen = 0; m_cnt = 0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input int v);
        bit h[3];
        exp_t e;
        m_mism = 0;
        if (!m_pv) begin
            m_pv = 1; m_prev = v;
        end else if (v == m_prev) begin
            m_frozen = 1;
        end else begin
            m_frozen = 0;
            for (int m = 0; m < 3; m++) begin
                h[m] = model_hit(m, m_prev, v);
                m_run[m] = h[m] ? ((m_run[m] + 1 > LOCK) ? LOCK : m_run[m] + 1) : 0;
            end
            if (m_locked) begin
                if (!h[m_mode]) begin
                    m_mism = 1; m_locked = 0;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else begin
                for (int m = 0; m < 3; m++)
                    if (!m_locked && m_run[m] == LOCK) begin
                        m_locked = 1; m_mode = m;
                    end
            end
            m_prev = v;
        end
        e.locked = m_locked; e.mode = 2'(m_mode); e.mism = m_mism;
        e.frozen = m_frozen; e.cnt = 16'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic do_step(input int v);
        @(negedge clk);
        step = 1'b1;
        q_in = 6'(v);
        model_step(v);
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one comparison set per sampled step, taken 1 time unit after the edge.
    always @(posedge clk) begin
        if (step === 1'b1 && reset === 1'b0) begin
            exp_t e;
            #1;
            n_steps++;
            if (exp_q.size() == 0) begin
                check("sb_pop", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("locked", locked, e.locked);
                check("mode_det", mode_det, e.mode);
                check("mismatch", mismatch, e.mism);
                check("frozen", frozen, e.frozen);
`ifdef LED_DEC_STATS_EN
                check("mismatch_cnt", mismatch_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s1[4]  = '{17, 16, 15, 14};
        int s2[7]  = '{31, 15, 7, 3, 1, 0, 31};
        int s3[5]  = '{0, 33, 51, 63, 0};
        int s4[6]  = '{17, 16, 15, 14, 13, 12};
        int s5[13] = '{31, 15, 7, 3, 1, 0, 31, 15, 7, 7, 7, 7, 3};
        int s6[4]  = '{0, 33, 51, 63};

        reset = 1'b1; step = 1'b0; q_in = '0;
        model_reset();
        #3;
        check("rst_locked", locked, 0);
        check("rst_mode", mode_det, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_frozen", frozen, 0);
`ifdef LED_DEC_STATS_EN
        check("rst_cnt", mismatch_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        foreach (s1[i]) do_step(s1[i]);
        check("t1_locked", locked, 1);

        apply_reset();
        foreach (s2[i]) do_step(s2[i]);
        check("t2_mode", mode_det, 1);

        apply_reset();
        foreach (s3[i]) do_step(s3[i]);
        check("t3_mode", mode_det, 2);

        apply_reset();
        foreach (s4[i]) do_step(s4[i]);
        do_step(5);
        @(posedge clk);
        #1;
        check("t4_pulse_end", mismatch, 0);
        check("t4_unlocked", locked, 0);
`ifdef LED_DEC_STATS_EN
        check("t4_cnt", mismatch_cnt, 1);
`endif

        apply_reset();
        foreach (s5[i]) do_step(s5[i]);
        check("t5_locked", locked, 1);

        apply_reset();
        foreach (s3[i]) do_step(s3[i]);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_locked", locked, 0);
        check("t6_async_frozen", frozen, 0);
        check("t6_async_mode", mode_det, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        foreach (s6[i]) begin
            do_step(s6[i]);
            if (i < 3) check("t6_relock_early", locked, 0);
        end
        check("t6_relock", locked, 1);

        // Random bursts of valid chains with occasional noise and repeats.
        apply_reset();
        for (int b = 0; b < 12; b++) begin
            int m;
            int idx;
            int len;
            m   = $urandom_range(0, 2);
            idx = $urandom_range(0, orbit_len(m) - 1);
            len = $urandom_range(3, 8);
            for (int k = 0; k < len; k++) begin
                int v;
                v = orbit_at(m, idx + k);
                if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 63);
                do_step(v);
                if ($urandom_range(0, 7) == 0) do_step(v);
            end
        end

        repeat (3) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
